// File: rtl/adc_sample_packetizer.sv
// ADC sample packetizer: buffers samples in a circular FIFO and serialises each one
// into a 3-byte frame ({4'hA, seq}, s16[15:8], s16[7:0]) for fifo_interface.
module adc_sample_packetizer #(
  parameter int SAMPLE_W   = 12,
  parameter int DEPTH_LOG2 = 3,
  parameter int MAX_RETRY  = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [SAMPLE_W-1:0]   sample_i,
  input  logic                  sample_vld_i,
  output logic                  tx_data_rdy_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ok_i,
  input  logic                  tx_err_i,
  input  logic                  tx_busy_i,
  output logic                  ovf_o,
  output logic [7:0]            drop_cnt_o,
  output logic [DEPTH_LOG2:0]   fill_o
);

  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int FILL_W  = DEPTH_LOG2 + 1;
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [FILL_W-1:0]     FILL_EMPTY = FILL_W'(1'b0);
  localparam logic [FILL_W-1:0]     FILL_ONE   = FILL_W'(1'b1);
  localparam logic [FILL_W-1:0]     FILL_FULL  = FILL_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);
  localparam logic [RETRY_W-1:0]    RETRY_ONE  = RETRY_W'(1'b1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  function automatic logic [15:0] zext16(input logic [SAMPLE_W-1:0] s);
    logic [15:0] r;
    r = 16'h0000;
    r[SAMPLE_W-1:0] = s;
    return r;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [3:0] seq,
                                            input logic [15:0] s16);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {4'hA, seq};
      2'd1:    b = s16[15:8];
      2'd2:    b = s16[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t                state_r, state_s;
  logic [SAMPLE_W-1:0]   mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r;
  logic [FILL_W-1:0]     fill_r;
  logic [15:0]           frame_s16_r;
  logic [3:0]            seq_r, frame_seq_r;
  logic [1:0]            byte_idx_r;
  logic [RETRY_W-1:0]    retry_r;
  logic                  tx_rdy_r;
  logic [7:0]            tx_data_r;
  logic                  ovf_r;
  logic [7:0]            drop_cnt_r;

  logic                  empty_s, full_s, push_s, pop_s, drop_s;
  logic                  strobe_s, byte_ok_s, retry_s, abandon_s;
  logic [1:0]            drop_inc_s;
  logic [8:0]            drop_sum_s;

  // Buffer status, push acceptance and saturating drop-count arithmetic
  always_comb begin
    empty_s    = (fill_r == FILL_EMPTY);
    full_s     = (fill_r == FILL_FULL);
    // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
    push_s     = sample_vld_i & (~full_s | pop_s);
    drop_s     = sample_vld_i & full_s & ~pop_s;
    drop_inc_s = {1'b0, drop_s} + {1'b0, abandon_s};
    drop_sum_s = {1'b0, drop_cnt_r} + {7'd0, drop_inc_s};
  end

  // Next-state and per-cycle control decode for the frame sender
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    strobe_s  = 1'b0;
    byte_ok_s = 1'b0;
    retry_s   = 1'b0;
    abandon_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A sample being written this cycle counts as present, giving the 3-cycle best case.
        if ((~empty_s | sample_vld_i) & ~tx_busy_i) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        pop_s   = 1'b1;
        state_s = ST_SEND;
      end
      ST_SEND: begin
        if (~tx_busy_i) begin
          strobe_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (tx_err_i) begin
          if (retry_r < RETRY_MAX) begin
            retry_s = 1'b1;
            state_s = ST_SEND;
          end else begin
            abandon_s = 1'b1;
            state_s   = ST_IDLE;
          end
        end else if (tx_ok_i) begin
          byte_ok_s = 1'b1;
          if (byte_idx_r == 2'd2) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Sample storage; occupancy is tracked by fill_r so the array itself needs no reset
  always_ff @(posedge clk_i) begin
    if (reset_ni && push_s) begin
      mem_r[wr_ptr_r] <= sample_i;
    end
  end

  // Buffer pointers, occupancy and overflow/drop bookkeeping
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
      fill_r     <= FILL_EMPTY;
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
      drop_cnt_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    end
  end

  // Frame register, sequence/byte/retry counters and the registered byte strobe
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      frame_s16_r <= 16'h0000;
      frame_seq_r <= 4'h0;
      seq_r       <= 4'h0;
      byte_idx_r  <= 2'd0;
      retry_r     <= {RETRY_W{1'b0}};
      tx_rdy_r    <= 1'b0;
      tx_data_r   <= 8'h00;
    end else begin
      // seq advances as each frame leaves the buffer, whether it later completes or not.
      if (pop_s) begin
        frame_s16_r <= zext16(mem_r[rd_ptr_r]);
        frame_seq_r <= seq_r;
        seq_r       <= seq_r + 4'd1;
        byte_idx_r  <= 2'd0;
        retry_r     <= {RETRY_W{1'b0}};
      end else begin
        if (byte_ok_s) begin
          byte_idx_r <= byte_idx_r + 2'd1;
        end
        if (retry_s) begin
          retry_r <= retry_r + RETRY_ONE;
        end
      end
      tx_rdy_r  <= strobe_s;
      tx_data_r <= strobe_s ? frame_byte(byte_idx_r, frame_seq_r, frame_s16_r) : 8'h00;
    end
  end

  assign tx_data_rdy_o = tx_rdy_r;
  assign tx_data_o     = tx_data_r;
  assign ovf_o         = ovf_r;
  assign drop_cnt_o    = drop_cnt_r;
  assign fill_o        = fill_r;

endmodule
